// File: rtl/ooo_issue_window.sv
// rtl/ooo_issue_window.sv - issue window with wakeup, oldest-ready select, in-order retire and branch flush
module ooo_issue_window #(
    parameter int DEPTH     = 8,
    parameter int IDX_W     = $clog2(DEPTH),
    parameter int PREG_W    = 6,
    parameter int NUM_WB    = 2,
    parameter int PAYLOAD_W = 96
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     disp_valid,
    output logic                     disp_ready,
    input  logic [PAYLOAD_W-1:0]     disp_payload,
    input  logic [2*PREG_W-1:0]      disp_src_preg,
    input  logic [1:0]               disp_src_rdy,
    input  logic                     disp_uses_rw,
    input  logic [PREG_W-1:0]        disp_rw_preg,
    output logic [IDX_W-1:0]         disp_tag,
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB*PREG_W-1:0] wb_preg,
    output logic                     iss_valid,
    input  logic                     iss_ready,
    output logic [PAYLOAD_W-1:0]     iss_payload,
    output logic [IDX_W-1:0]         iss_tag,
    input  logic                     cmp_valid,
    input  logic [IDX_W-1:0]         cmp_tag,
    input  logic                     flush_valid,
    input  logic [IDX_W-1:0]         flush_tag,
    output logic                     ret_valid,
    output logic [IDX_W-1:0]         ret_tag,
    output logic                     ret_uses_rw,
    output logic [PREG_W-1:0]        ret_rw_preg,
    output logic [IDX_W:0]           count
);
    typedef enum logic [1:0] {ST_FREE, ST_WAIT, ST_ISSUED, ST_DONE} ent_state_t;

    localparam logic [IDX_W:0] FULL = (IDX_W+1)'(DEPTH);

    ent_state_t           st       [DEPTH];
    logic [PAYLOAD_W-1:0] pay      [DEPTH];
    logic [PREG_W-1:0]    src_preg [DEPTH][2];
    logic [1:0]           src_rdy  [DEPTH];
    logic                 uses_rw  [DEPTH];
    logic [PREG_W-1:0]    rw_preg  [DEPTH];
    logic [IDX_W-1:0]     head, tail;

    logic [IDX_W-1:0] sel, idx_c, rel, flush_off;
    logic             found, disp_fire, iss_fire, ret_fire, flush_ok;
    logic [1:0]       disp_rdy_eff;
    logic [1:0]       wake [DEPTH];
    logic [DEPTH-1:0] flushed;

    function automatic logic wb_hit(input logic [PREG_W-1:0] p,
                                    input logic [NUM_WB-1:0] v,
                                    input logic [NUM_WB*PREG_W-1:0] pr);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_WB; k++)
            if (v[k] && pr[k*PREG_W +: PREG_W] == p) hit = 1'b1;
        return hit;
    endfunction

    assign disp_ready  = !rst && (count < FULL) && !flush_valid;
    assign disp_fire   = disp_valid && disp_ready;
    assign disp_tag    = tail;
    assign flush_off   = flush_tag - head;
    assign flush_ok    = flush_valid && ({1'b0, flush_off} < count);
    assign ret_fire    = (count != '0) && (st[head] == ST_DONE);
    assign iss_valid   = found && !flush_valid && !rst;
    assign iss_tag     = sel;
    assign iss_payload = pay[sel];
    assign iss_fire    = iss_valid && iss_ready;

    // Scan from head so the first hit is the oldest ready entry.
    always_comb begin
        found = 1'b0;
        sel   = head;
        idx_c = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx_c = head + IDX_W'(i);
            if (!found && st[idx_c] == ST_WAIT && (&src_rdy[idx_c])) begin
                found = 1'b1;
                sel   = idx_c;
            end
        end
    end

    always_comb begin
        rel     = '0;
        flushed = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rel        = IDX_W'(i) - head;
            flushed[i] = flush_ok && (rel > flush_off) && ({1'b0, rel} < count);
            for (int s = 0; s < 2; s++)
                wake[i][s] = wb_hit(src_preg[i][s], wb_valid, wb_preg);
        end
        for (int s = 0; s < 2; s++)
            disp_rdy_eff[s] = disp_src_rdy[s] |
                              wb_hit(disp_src_preg[s*PREG_W +: PREG_W], wb_valid, wb_preg);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            ret_valid   <= 1'b0;
            ret_tag     <= '0;
            ret_uses_rw <= 1'b0;
            ret_rw_preg <= '0;
            for (int i = 0; i < DEPTH; i++) st[i] <= ST_FREE;
        end else begin
            ret_valid <= ret_fire;
            if (ret_fire) begin
                ret_tag     <= head;
                ret_uses_rw <= uses_rw[head];
                ret_rw_preg <= rw_preg[head];
                head        <= head + IDX_W'(1);
            end
            // Dispatch is blocked during a flush, so only retire adjusts the flushed count.
            if (flush_ok) begin
                tail  <= flush_tag + IDX_W'(1);
                count <= {1'b0, flush_off} + (IDX_W+1)'(1) - (IDX_W+1)'(ret_fire);
            end else begin
                tail  <= tail + IDX_W'(disp_fire);
                count <= count + (IDX_W+1)'(disp_fire) - (IDX_W+1)'(ret_fire);
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (flushed[i] || (ret_fire && head == IDX_W'(i)))
                    st[i] <= ST_FREE;
                else if (disp_fire && tail == IDX_W'(i))
                    st[i] <= ST_WAIT;
                else if (iss_fire && sel == IDX_W'(i))
                    st[i] <= ST_ISSUED;
                else if (cmp_valid && cmp_tag == IDX_W'(i) && st[i] == ST_ISSUED)
                    st[i] <= ST_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (disp_fire && tail == IDX_W'(i)) begin
                pay[i]         <= disp_payload;
                src_preg[i][0] <= disp_src_preg[PREG_W-1:0];
                src_preg[i][1] <= disp_src_preg[2*PREG_W-1:PREG_W];
                src_rdy[i]     <= disp_rdy_eff;
                uses_rw[i]     <= disp_uses_rw;
                rw_preg[i]     <= disp_rw_preg;
            end else begin
                src_rdy[i] <= src_rdy[i] | wake[i];
            end
        end
    end
endmodule

// File: tb/tb_ooo_issue_window.sv
// tb/tb_ooo_issue_window.sv - directed vectors, corner sequences and random run against a queue model
module tb_ooo_issue_window;
    localparam int DEPTH = 8, IDX_W = 3, PREG_W = 6, NUM_WB = 2, PAYLOAD_W = 96;
    localparam int M_WAIT = 0, M_ISS = 1, M_DONE = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     disp_valid, disp_ready;
    logic [PAYLOAD_W-1:0]     disp_payload;
    logic [2*PREG_W-1:0]      disp_src_preg;
    logic [1:0]               disp_src_rdy;
    logic                     disp_uses_rw;
    logic [PREG_W-1:0]        disp_rw_preg;
    logic [IDX_W-1:0]         disp_tag;
    logic [NUM_WB-1:0]        wb_valid;
    logic [NUM_WB*PREG_W-1:0] wb_preg;
    logic                     iss_valid, iss_ready;
    logic [PAYLOAD_W-1:0]     iss_payload;
    logic [IDX_W-1:0]         iss_tag;
    logic                     cmp_valid;
    logic [IDX_W-1:0]         cmp_tag;
    logic                     flush_valid;
    logic [IDX_W-1:0]         flush_tag;
    logic                     ret_valid;
    logic [IDX_W-1:0]         ret_tag;
    logic                     ret_uses_rw;
    logic [PREG_W-1:0]        ret_rw_preg;
    logic [IDX_W:0]           count;

    ooo_issue_window #(.DEPTH(DEPTH), .IDX_W(IDX_W), .PREG_W(PREG_W), .NUM_WB(NUM_WB),
                       .PAYLOAD_W(PAYLOAD_W)) dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_payload(disp_payload),
        .disp_src_preg(disp_src_preg), .disp_src_rdy(disp_src_rdy),
        .disp_uses_rw(disp_uses_rw), .disp_rw_preg(disp_rw_preg), .disp_tag(disp_tag),
        .wb_valid(wb_valid), .wb_preg(wb_preg),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_payload(iss_payload), .iss_tag(iss_tag),
        .cmp_valid(cmp_valid), .cmp_tag(cmp_tag),
        .flush_valid(flush_valid), .flush_tag(flush_tag),
        .ret_valid(ret_valid), .ret_tag(ret_tag), .ret_uses_rw(ret_uses_rw),
        .ret_rw_preg(ret_rw_preg), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  tag;
        int          st;
        logic [5:0]  p0, p1;
        logic        r0, r1;
        logic        u;
        logic [5:0]  rw;
        logic [95:0] pay;
    } ment_t;

    typedef struct {
        logic       dv;
        logic [1:0] srdy;
        logic [5:0] sp0, sp1;
        logic       ir;
        logic [1:0] wbv;
        logic [5:0] wbp;
        logic       cv;
        logic [2:0] ct;
        logic       e_dr;
        logic [2:0] e_dt;
        logic       e_iv;
        logic [2:0] e_it;
        logic       e_rv;
        logic [2:0] e_rt;
        logic [3:0] e_cnt;
    } vec_t;

    int n_chk = 0, n_err = 0;
    ment_t mq[$];
    vec_t  vt[$];
    int    m_tail;
    logic  m_rv, m_ru;
    logic [2:0] m_rt;
    logic [5:0] m_rp;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic hit(input logic [5:0] p);
        return (wb_valid[0] && wb_preg[5:0] == p) || (wb_valid[1] && wb_preg[11:6] == p);
    endfunction

    task automatic model_clear();
        mq.delete();
        m_tail = 0;
        m_rv = 1'b0; m_rt = '0; m_ru = 1'b0; m_rp = '0;
    endtask

    // Compare every DUT output against the model, mid-cycle.
    task automatic at_neg();
        int   ip;
        logic e_iv;
        @(negedge clk);
        ip = -1;
        foreach (mq[i])
            if (ip < 0 && mq[i].st == M_WAIT && mq[i].r0 && mq[i].r1) ip = i;
        e_iv = (ip >= 0) && !rst && !flush_valid;
        chk("m_disp_ready", 96'(disp_ready), 96'(!rst && mq.size() < DEPTH && !flush_valid));
        chk("m_disp_tag", 96'(disp_tag), 96'(m_tail));
        chk("m_count", 96'(count), 96'(mq.size()));
        chk("m_iss_valid", 96'(iss_valid), 96'(e_iv));
        if (e_iv) begin
            chk("m_iss_tag", 96'(iss_tag), 96'(mq[ip].tag));
            chk("m_iss_payload", iss_payload, mq[ip].pay);
        end
        chk("m_ret_valid", 96'(ret_valid), 96'(m_rv));
        if (m_rv) begin
            chk("m_ret_tag", 96'(ret_tag), 96'(m_rt));
            chk("m_ret_uses_rw", 96'(ret_uses_rw), 96'(m_ru));
            chk("m_ret_rw_preg", 96'(ret_rw_preg), 96'(m_rp));
        end
    endtask

    task automatic model_step();
        bit    ret, dfire;
        int    ip, cp, fp;
        ment_t e;
        if (rst) begin
            model_clear();
            return;
        end
        ret = mq.size() > 0 && mq[0].st == M_DONE;
        ip = -1; cp = -1; fp = -1;
        foreach (mq[i]) begin
            if (ip < 0 && mq[i].st == M_WAIT && mq[i].r0 && mq[i].r1) ip = i;
            if (cmp_valid && mq[i].tag == cmp_tag && mq[i].st == M_ISS) cp = i;
            if (flush_valid && mq[i].tag == flush_tag) fp = i;
        end
        dfire = disp_valid && mq.size() < DEPTH && !flush_valid;
        if (ip >= 0 && iss_ready && !flush_valid) mq[ip].st = M_ISS;
        if (cp >= 0) mq[cp].st = M_DONE;
        foreach (mq[i])
            if (mq[i].st == M_WAIT) begin
                if (hit(mq[i].p0)) mq[i].r0 = 1'b1;
                if (hit(mq[i].p1)) mq[i].r1 = 1'b1;
            end
        m_rv = ret;
        if (ret) begin
            m_rt = mq[0].tag; m_ru = mq[0].u; m_rp = mq[0].rw;
        end
        if (fp >= 0) begin
            while (mq.size() > fp + 1) void'(mq.pop_back());
            m_tail = (int'(flush_tag) + 1) % DEPTH;
        end
        if (ret) void'(mq.pop_front());
        if (dfire) begin
            e.tag = 3'(m_tail);
            e.st  = M_WAIT;
            e.p0  = disp_src_preg[5:0];
            e.p1  = disp_src_preg[11:6];
            e.r0  = disp_src_rdy[0] | hit(e.p0);
            e.r1  = disp_src_rdy[1] | hit(e.p1);
            e.u   = disp_uses_rw;
            e.rw  = disp_rw_preg;
            e.pay = disp_payload;
            mq.push_back(e);
            m_tail = (m_tail + 1) % DEPTH;
        end
    endtask

    task automatic edge_();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        at_neg();
        edge_();
    endtask

    task automatic clr();
        rst = 1'b0; disp_valid = 1'b0; disp_src_rdy = '0; disp_src_preg = '0;
        disp_uses_rw = 1'b0; disp_rw_preg = '0; disp_payload = '0;
        wb_valid = '0; wb_preg = '0; iss_ready = 1'b0;
        cmp_valid = 1'b0; cmp_tag = '0; flush_valid = 1'b0; flush_tag = '0;
    endtask

    task automatic dsp(input logic [1:0] srdy);
        disp_valid   = 1'b1;
        disp_src_rdy = srdy;
        disp_payload = {$urandom, $urandom, $urandom};
        disp_uses_rw = 1'($urandom);
        disp_rw_preg = 6'($urandom);
    endtask

    task automatic do_reset();
        clr();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic addv(input int dv, srdy, sp0, sp1, ir, wbv, wbp, cv, ct,
                        dr, dt, iv, it, rv, rt, cnt);
        vec_t v;
        v.dv = 1'(dv); v.srdy = 2'(srdy); v.sp0 = 6'(sp0); v.sp1 = 6'(sp1); v.ir = 1'(ir);
        v.wbv = 2'(wbv); v.wbp = 6'(wbp); v.cv = 1'(cv); v.ct = 3'(ct);
        v.e_dr = 1'(dr); v.e_dt = 3'(dt); v.e_iv = 1'(iv); v.e_it = 3'(it);
        v.e_rv = 1'(rv); v.e_rt = 3'(rt); v.e_cnt = 4'(cnt);
        vt.push_back(v);
    endtask

    task automatic rand_inputs();
        int n;
        n = mq.size();
        clr();
        rst = ($urandom_range(0, 249) == 0);
        if ($urandom_range(0, 3) != 0) dsp(2'($urandom));
        disp_src_preg = {6'($urandom_range(0, 15)), 6'($urandom_range(0, 15))};
        wb_valid = 2'($urandom);
        wb_preg = {6'($urandom_range(0, 15)), 6'($urandom_range(0, 15))};
        iss_ready = ($urandom_range(0, 3) != 0);
        cmp_valid = 1'($urandom);
        if (n > 0) cmp_tag = mq[$urandom_range(0, n - 1)].tag;
        else cmp_tag = 3'($urandom);
        flush_valid = ($urandom_range(0, 24) == 0);
        if (n > 0 && $urandom_range(0, 4) != 0) flush_tag = mq[$urandom_range(0, n - 1)].tag;
        else flush_tag = 3'($urandom);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: run did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_disp_ready", 96'(disp_ready), 96'(0));
        chk("rst_iss_valid", 96'(iss_valid), 96'(0));
        chk("rst_count", 96'(count), 96'(0));
        chk("rst_ret_valid", 96'(ret_valid), 96'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();

        //     dv sr s0 s1 ir wv wp cv ct | dr dt iv it rv rt cnt
        addv(1, 3, 0, 0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
        addv(1, 3, 0, 0, 1, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0, 1);
        addv(1, 3, 0, 0, 1, 0, 0, 0, 0,   1, 2, 1, 1, 0, 0, 2);
        addv(0, 0, 0, 0, 1, 0, 0, 0, 0,   1, 3, 1, 2, 0, 0, 3);
        addv(0, 0, 0, 0, 1, 0, 0, 1, 0,   1, 3, 0, 0, 0, 0, 3);
        addv(0, 0, 0, 0, 1, 0, 0, 1, 1,   1, 3, 0, 0, 0, 0, 3);
        addv(0, 0, 0, 0, 1, 0, 0, 1, 2,   1, 3, 0, 0, 1, 0, 2);
        addv(0, 0, 0, 0, 1, 0, 0, 0, 0,   1, 3, 0, 0, 1, 1, 1);
        addv(0, 0, 0, 0, 1, 0, 0, 0, 0,   1, 3, 0, 0, 1, 2, 0);
        addv(0, 0, 0, 0, 1, 0, 0, 0, 0,   1, 3, 0, 0, 0, 0, 0);
        addv(1, 0, 5, 6, 1, 0, 0, 0, 0,   1, 3, 0, 0, 0, 0, 0);
        addv(1, 3, 0, 0, 1, 0, 0, 0, 0,   1, 4, 0, 0, 0, 0, 1);
        addv(0, 0, 0, 0, 1, 0, 0, 0, 0,   1, 5, 1, 4, 0, 0, 2);
        addv(0, 0, 0, 0, 1, 1, 5, 0, 0,   1, 5, 0, 0, 0, 0, 2);
        addv(0, 0, 0, 0, 1, 1, 6, 0, 0,   1, 5, 0, 0, 0, 0, 2);
        addv(0, 0, 0, 0, 1, 0, 0, 1, 4,   1, 5, 1, 3, 0, 0, 2);
        addv(0, 0, 0, 0, 1, 0, 0, 0, 0,   1, 5, 0, 0, 0, 0, 2);
        addv(0, 0, 0, 0, 1, 0, 0, 1, 3,   1, 5, 0, 0, 0, 0, 2);
        addv(0, 0, 0, 0, 1, 0, 0, 0, 0,   1, 5, 0, 0, 0, 0, 2);
        addv(0, 0, 0, 0, 1, 0, 0, 0, 0,   1, 5, 0, 0, 1, 3, 1);
        addv(0, 0, 0, 0, 1, 0, 0, 0, 0,   1, 5, 0, 0, 1, 4, 0);
        addv(0, 0, 0, 0, 1, 0, 0, 0, 0,   1, 5, 0, 0, 0, 0, 0);

        foreach (vt[i]) begin
            clr();
            if (vt[i].dv) dsp(vt[i].srdy);
            disp_src_preg = {vt[i].sp1, vt[i].sp0};
            iss_ready = vt[i].ir;
            wb_valid = vt[i].wbv;
            wb_preg = {6'd0, vt[i].wbp};
            cmp_valid = vt[i].cv;
            cmp_tag = vt[i].ct;
            at_neg();
            chk("vec_disp_ready", 96'(disp_ready), 96'(vt[i].e_dr));
            chk("vec_disp_tag", 96'(disp_tag), 96'(vt[i].e_dt));
            chk("vec_iss_valid", 96'(iss_valid), 96'(vt[i].e_iv));
            if (vt[i].e_iv) chk("vec_iss_tag", 96'(iss_tag), 96'(vt[i].e_it));
            chk("vec_ret_valid", 96'(ret_valid), 96'(vt[i].e_rv));
            if (vt[i].e_rv) chk("vec_ret_tag", 96'(ret_tag), 96'(vt[i].e_rt));
            chk("vec_count", 96'(count), 96'(vt[i].e_cnt));
            edge_();
        end

        // Fill to capacity, then retire the head and wrap the tail.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            clr(); dsp(i == 0 ? 2'b11 : 2'b00); iss_ready = 1'b1; step();
        end
        clr(); dsp(2'b00); cmp_valid = 1'b1; cmp_tag = 3'd0;
        at_neg();
        chk("full_disp_ready", 96'(disp_ready), 96'(0));
        chk("full_count", 96'(count), 96'(8));
        edge_();
        clr(); dsp(2'b00);
        at_neg();
        chk("full_retire_blocks", 96'(disp_ready), 96'(0));
        edge_();
        clr(); dsp(2'b00);
        at_neg();
        chk("wrap_disp_ready", 96'(disp_ready), 96'(1));
        chk("wrap_disp_tag", 96'(disp_tag), 96'(0));
        chk("wrap_count", 96'(count), 96'(7));
        edge_();

        // Move head to 2, occupy tags 2..7, then flush at tag 4.
        do_reset();
        clr(); dsp(2'b11); step();
        clr(); dsp(2'b11); iss_ready = 1'b1; step();
        clr(); iss_ready = 1'b1; cmp_valid = 1'b1; cmp_tag = 3'd0; step();
        clr(); cmp_valid = 1'b1; cmp_tag = 3'd1; step();
        clr(); step();
        clr(); dsp(2'b11);
        at_neg();
        chk("pre_flush_count", 96'(count), 96'(0));
        chk("pre_flush_tag", 96'(disp_tag), 96'(2));
        edge_();
        clr(); dsp(2'b11); iss_ready = 1'b1; step();
        for (int i = 0; i < 4; i++) begin
            clr(); dsp(2'b00); step();
        end
        clr(); dsp(2'b00); flush_valid = 1'b1; flush_tag = 3'd4; cmp_valid = 1'b1; cmp_tag = 3'd2;
        at_neg();
        chk("flush_disp_ready", 96'(disp_ready), 96'(0));
        chk("flush_iss_valid", 96'(iss_valid), 96'(0));
        chk("flush_cycle_count", 96'(count), 96'(6));
        edge_();
        clr(); dsp(2'b00); cmp_valid = 1'b1; cmp_tag = 3'd6;
        at_neg();
        chk("post_flush_count", 96'(count), 96'(3));
        chk("post_flush_tag", 96'(disp_tag), 96'(5));
        chk("post_flush_ready", 96'(disp_ready), 96'(1));
        edge_();
        clr();
        at_neg();
        chk("flush_cmp_ret_valid", 96'(ret_valid), 96'(1));
        chk("flush_cmp_ret_tag", 96'(ret_tag), 96'(2));
        chk("flush_cmp_count", 96'(count), 96'(3));
        edge_();

        // Reset with five entries in flight.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            clr(); dsp(2'b11); iss_ready = 1'b1; step();
        end
        clr(); rst = 1'b1; dsp(2'b11); iss_ready = 1'b1;
        at_neg();
        chk("midrst_disp_ready", 96'(disp_ready), 96'(0));
        chk("midrst_iss_valid", 96'(iss_valid), 96'(0));
        edge_();
        clr(); dsp(2'b11);
        at_neg();
        chk("after_rst_count", 96'(count), 96'(0));
        chk("after_rst_ret_valid", 96'(ret_valid), 96'(0));
        chk("after_rst_iss_valid", 96'(iss_valid), 96'(0));
        chk("after_rst_disp_ready", 96'(disp_ready), 96'(1));
        chk("after_rst_disp_tag", 96'(disp_tag), 96'(0));
        edge_();

        for (int c = 0; c < 3000; c++) begin
            rand_inputs();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/ooo_issue_window.md
# ooo_issue_window

Parametrised issue window with in-order retirement for the out-of-order MIPS core, sitting between decode/rename and the execution glue stage. It accepts one renamed instruction per cycle into a circular buffer of DEPTH entries, wakes source operands from NUM_WB writeback broadcasts, and issues the oldest ready entry to execution. It marks entries complete and retires them strictly in program order. On a branch mispredict it flushes every entry younger than the branch.

## Interface
- DEPTH, 8: number of entries; power of two, 4–32.
- IDX_W, $clog2(DEPTH): entry index width; the index is the instruction tag.
- PREG_W, 6: physical register address width.
- NUM_WB, 2: number of wakeup (writeback) broadcast ports.
- PAYLOAD_W, 96: opaque decoded-instruction payload width (alu_ctl, immediate, branch target and so on), passed through untouched.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  window can accept this cycle.
- disp_payload  in  PAYLOAD_W  decoded instruction.
- disp_src_preg  in  2×PREG_W  physical sources rs and rt.
- disp_src_rdy  in  2  source already available, or source unused.
- disp_uses_rw, disp_rw_preg  in  1, PREG_W  destination.
- disp_tag  out  IDX_W  slot assigned to this dispatch (equals tail).
- wb_valid  in  NUM_WB  wakeup strobes.
- wb_preg  in  NUM_WB×PREG_W  registers becoming available.
- iss_valid  out  1  an entry is ready to issue.
- iss_ready  in  1  execution accepts.
- iss_payload  out  PAYLOAD_W  payload of the selected entry.
- iss_tag  out  IDX_W  tag of the selected entry.
- cmp_valid, cmp_tag  in  1, IDX_W  execution finished the tagged entry.
- flush_valid, flush_tag  in  1, IDX_W  mispredicted branch; all entries younger than flush_tag are discarded, the branch itself is kept.
- ret_valid  out  1  one instruction retired (registered pulse).
- ret_tag  out  IDX_W  tag of the retired instruction.
- ret_uses_rw, ret_rw_preg  out  1, PREG_W  destination of the retired instruction, used to free the old mapping.
- count  out  IDX_W+1  occupied entries.

## Operation
- Each entry has a state: FREE, WAIT, ISSUED or DONE. It also holds the payload, two source pregs, two source-ready bits and the destination.
- Registers: head, tail (IDX_W bits, wrap modulo DEPTH) and count (0..DEPTH).
- disp_ready is !rst && count<DEPTH && !flush_valid.
- Dispatch: a dispatch fires when disp_valid && disp_ready.
  - The entry at tail is written and set to WAIT; tail increments.
  - Each source-ready bit is disp_src_rdy[i] OR a same-cycle wb_valid[k] with a matching wb_preg[k] (wakeup bypass).
- Wakeup: every WAIT entry sets each source-ready bit whose preg matches any valid wb port. All ports are applied in parallel.
- Select: among WAIT entries with both ready bits set, pick the one with the smallest (idx−head) mod DEPTH, i.e. the oldest. The select is combinational.
  - iss_valid is found && !flush_valid.
  - iss_payload and iss_tag come from the selected entry.
  - On iss_valid && iss_ready the entry becomes ISSUED.
- Complete: cmp_valid moves the entry from ISSUED to DONE. A complete for an entry in any other state is ignored.
- Retire: when count>0 and entry[head] is DONE:
  - the entry becomes FREE and head increments;
  - next cycle, ret_valid=1 and ret_tag, ret_uses_rw and ret_rw_preg carry that entry's fields.
  - Otherwise ret_valid=0. At most one retire per cycle.
- Flush: flush_valid with flush_tag inside the occupied range.
  - All entries in (flush_tag, tail) become FREE.
  - tail becomes flush_tag+1.
  - count becomes ((flush_tag−head) mod DEPTH)+1, minus 1 if head retires in the same cycle.
  - A flush_tag outside the occupied range is a protocol violation; the block ignores the flush.
- Simultaneous events:
  - Flush beats dispatch: disp_ready is low during a flush.
  - Complete and flush in the same cycle both apply; a complete for a flushed tag is dropped.
  - Retire and dispatch in the same cycle: count is unchanged.
  - Dispatch when count==DEPTH is blocked, even if a retire occurs that cycle (no same-cycle reuse).
- Reset: head=tail=count=0, all entries FREE, ret_valid=0, ret_tag=0, ret_uses_rw=0, ret_rw_preg=0. Combinational outputs follow, giving iss_valid=0 and disp_ready=0 while rst is high. A reset mid-operation discards all contents.

## Timing
- Dispatch in cycle c: the entry can issue in c+1 at the earliest.
- Wakeup in cycle c: a matching stored entry can issue in c+1. Dispatch and wakeup in the same cycle also allows issue in c+1.
- Complete in c with the entry at head: it retires at the end of c+1, and ret_valid is high in c+2.
- Flush in c: the new tail is visible in c+1. disp_ready and iss_valid are low during c only.
- Throughput: 1 dispatch, 1 issue and 1 retire per cycle.

## Test plan
- Reset, then dispatch 3 entries with src_rdy=11 and iss_ready=1 → iss_tag 0,1,2 in consecutive cycles starting one cycle after the first dispatch. Then complete 0,1,2 → ret_valid with ret_tag 0,1,2 in order, each 2 cycles after its complete.
- Dispatch A (src_rdy=00, preg 5/6), then B (src_rdy=11) → B issues first. Then wb_valid=01 with preg 5, followed by preg 6 → A issues the cycle after preg 6 arrives. Completing B first gives no retire until A completes; then A retires, followed by B.
- Fill to DEPTH=8 → disp_ready=0 and count=8. Retire one → disp_ready=1 next cycle, tail wraps to 0, and the new entry gets disp_tag=0.
- Occupy tags 2..7 with head=2, then flush_tag=4 → count=3, tail=5. A complete for tag 6 is ignored, and the next dispatch gets disp_tag=5.
- Flush, dispatch and complete in the same cycle → dispatch dropped, disp_ready=0 and iss_valid=0 that cycle, and the complete of an unflushed entry still applies.
- Assert rst mid-run with 5 entries in flight → next cycle count=0, ret_valid=0, iss_valid=0. After rst deasserts, disp_ready=1 and the first dispatch gets disp_tag=0.
